// File: rtl/lifo_stack_pkg.sv
// lifo_stack shared encodings: op codes and status codes.
// NONE=0 is common to both.
package lifo_stack_pkg;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_NONE      = 2'd0,
    ST_EMPTY     = 2'd1,
    ST_OVERFLOW  = 2'd2,
    ST_UNDERFLOW = 2'd3
  } status_t;

endpackage

// File: rtl/lifo_stack.sv
// LIFO stack, 2^DEPTH x WIDTH, registered tos and status.
// Define STACK_COUNT_EN to export the entry count as port count.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] tos,
  output logic [1:0]       status
`ifdef STACK_COUNT_EN
  ,
  output logic [DEPTH:0]   count
`endif
);

  localparam int NENT = 1 << DEPTH;
  localparam logic [DEPTH:0] ONE  = (DEPTH+1)'(1);
  localparam logic [DEPTH:0] TWO  = (DEPTH+1)'(2);
  localparam logic [DEPTH:0] FULL = {1'b1, {DEPTH{1'b0}}};

  logic [WIDTH-1:0] mem [NENT];
  logic [DEPTH:0]   sp = '0;
  logic [1:0]       st_q = ST_EMPTY;
  logic [WIDTH-1:0] tos_q;

  logic [DEPTH:0]   sp_n;
  logic [1:0]       st_n;
  logic [WIDTH-1:0] tos_n;
  logic             we;
  logic [DEPTH-1:0] waddr;
  logic [DEPTH-1:0] i1;
  logic [DEPTH-1:0] i2;

  assign i1 = DEPTH'(sp - ONE);
  assign i2 = DEPTH'(sp - TWO);

  // Decode op against the current fill level.
  always_comb begin
    sp_n  = sp;
    st_n  = ST_NONE;
    tos_n = tos_q;
    we    = 1'b0;
    waddr = sp[DEPTH-1:0];
    unique case (op_t'(op))
      OP_PUSH: begin
        if (sp == FULL) begin
          st_n = ST_OVERFLOW;
        end else begin
          we    = 1'b1;
          sp_n  = sp + ONE;
          tos_n = data;
        end
      end
      OP_POP: begin
        if (sp == '0) begin
          st_n = ST_UNDERFLOW;
        end else if (sp == ONE) begin
          sp_n = '0;
          st_n = ST_EMPTY;
        end else begin
          sp_n  = sp - ONE;
          tos_n = mem[i2];
        end
      end
      OP_REPLACE: begin
        if (sp == '0) begin
          st_n = ST_UNDERFLOW;
        end else begin
          we    = 1'b1;
          waddr = i1;
          tos_n = data;
        end
      end
      OP_NONE: begin
        st_n = (sp == '0) ? ST_EMPTY : ST_NONE;
      end
    endcase
  end

  // Pointer and status: the only state cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp   <= '0;
      st_q <= ST_EMPTY;
    end else begin
      sp   <= sp_n;
      st_q <= st_n;
    end
  end

  // Storage and tos keep their contents across reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tos_q <= tos_n;
      if (we) mem[waddr] <= data;
    end
  end

  assign tos    = tos_q;
  assign status = st_q;

`ifdef STACK_COUNT_EN
  assign count = sp;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack, WIDTH=8 DEPTH=1.
// Covers count too when STACK_COUNT_EN is defined.
module tb_lifo_stack;
  import lifo_stack_pkg::*;

  logic       clk;
  logic       reset;
  logic [1:0] op;
  logic [7:0] data;
  logic [7:0] tos;
  logic [1:0] status;
`ifdef STACK_COUNT_EN
  logic [1:0] count;
`endif

  int n_chk;
  int n_fail;

  lifo_stack #(.WIDTH(8), .DEPTH(1)) dut (
    .clk    (clk),
    .reset  (reset),
    .op     (op),
    .data   (data),
    .tos    (tos),
    .status (status)
`ifdef STACK_COUNT_EN
    ,
    .count  (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] o, input logic [7:0] d);
    @(negedge clk);
    op   = o;
    data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic cnt(input string tag, input int exp);
`ifdef STACK_COUNT_EN
    check(tag, 32'(count), 32'(exp));
`else
    if (tag.len() < 0 || exp < 0) $display("unused");
`endif
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    op     = OP_NONE;
    data   = 8'h00;
    #1;
    check("powerup_st", 32'(status), 32'(ST_EMPTY));
    cnt("powerup_cnt", 0);

    step(OP_NONE, 8'hAA);
    check("idle_st", 32'(status), 32'(ST_EMPTY));
    cnt("idle_cnt", 0);
    step(OP_POP, 8'hAA);
    check("pop_empty_st", 32'(status), 32'(ST_UNDERFLOW));

    step(OP_PUSH, 8'h00);
    check("push0_st", 32'(status), 32'(ST_NONE));
    check("push0_tos", 32'(tos), 32'h00);
    cnt("push0_cnt", 1);
    step(OP_PUSH, 8'h01);
    check("push1_st", 32'(status), 32'(ST_NONE));
    check("push1_tos", 32'(tos), 32'h01);
    cnt("push1_cnt", 2);
    step(OP_NONE, 8'h55);
    check("nop_st", 32'(status), 32'(ST_NONE));
    check("nop_tos", 32'(tos), 32'h01);

    step(OP_PUSH, 8'h03);
    check("ovf_st", 32'(status), 32'(ST_OVERFLOW));
    check("ovf_tos", 32'(tos), 32'h01);
    cnt("ovf_cnt", 2);
    step(OP_POP, 8'hFF);
    check("pop2_st", 32'(status), 32'(ST_NONE));
    check("pop2_tos", 32'(tos), 32'h00);
    cnt("pop2_cnt", 1);
    step(OP_POP, 8'hFF);
    check("pop1_st", 32'(status), 32'(ST_EMPTY));
    cnt("pop1_cnt", 0);

    step(OP_REPLACE, 8'h04);
    check("rep_empty_st", 32'(status), 32'(ST_UNDERFLOW));
    cnt("rep_empty_cnt", 0);
    step(OP_PUSH, 8'h05);
    check("push5_st", 32'(status), 32'(ST_NONE));
    check("push5_tos", 32'(tos), 32'h05);
    step(OP_REPLACE, 8'h06);
    check("rep6_st", 32'(status), 32'(ST_NONE));
    check("rep6_tos", 32'(tos), 32'h06);
    cnt("rep6_cnt", 1);
    step(OP_NONE, 8'h00);
    check("nop6_st", 32'(status), 32'(ST_NONE));
    check("nop6_tos", 32'(tos), 32'h06);

    @(negedge clk);
    op    = OP_PUSH;
    data  = 8'h99;
    reset = 1'b0;
    #1;
    check("rst_async_st", 32'(status), 32'(ST_EMPTY));
    cnt("rst_async_cnt", 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_st", 32'(status), 32'(ST_EMPTY));
    check("rst_tos", 32'(tos), 32'h06);
    cnt("rst_cnt", 0);
    @(negedge clk);
    reset = 1'b1;
    op    = OP_NONE;

    step(OP_POP, 8'h00);
    check("post_rst_pop_st", 32'(status), 32'(ST_UNDERFLOW));
    check("post_rst_pop_tos", 32'(tos), 32'h06);

    step(OP_PUSH, 8'h07);
    check("push7_tos", 32'(tos), 32'h07);
    step(OP_PUSH, 8'h08);
    check("push8_tos", 32'(tos), 32'h08);
    cnt("push8_cnt", 2);
    step(OP_POP, 8'h00);
    check("pop_to7_st", 32'(status), 32'(ST_NONE));
    check("pop_to7_tos", 32'(tos), 32'h07);
    step(OP_NONE, 8'h00);
    check("nop7_st", 32'(status), 32'(ST_NONE));
    step(OP_POP, 8'h00);
    check("pop_last_st", 32'(status), 32'(ST_EMPTY));
    step(OP_NONE, 8'h00);
    check("final_idle_st", 32'(status), 32'(ST_EMPTY));
    cnt("final_cnt", 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
